// File: rtl/grf_wb_queue.sv
// GRF write-port front end: merges W-stage writes with buffered MDU results and
// reports which registers still have a queued write pending.
module grf_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_a3,
    input  logic [31:0] pipe_wd,
    input  logic [31:0] pipe_pc,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_a3,
    input  logic [31:0] mdu_wd,
    input  logic [31:0] mdu_pc,
    input  logic [4:0]  q_a1,
    input  logic [4:0]  q_a2,
    output logic        q_busy1,
    output logic        q_busy2,
    output logic        WE,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    output logic [31:0] pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [4:0]       a3_q [DEPTH];
    logic [31:0]      wd_q [DEPTH];
    logic [31:0]      pc_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic pipe_act, fifo_empty, head_vld, pop, push, push_vld;

    always_comb begin
        pipe_act   = pipe_we && (pipe_a3 != 5'd0);
        fifo_empty = (cnt_q == '0);
        head_vld   = vld_q[rd_ptr_q];
        // Any slot at the head leaves when the pipeline is not using the port,
        // whether it carries a write or was killed.
        pop        = !pipe_act && !fifo_empty;
        mdu_ready  = !reset && (cnt_q != FULL_CNT);
        push       = mdu_valid && mdu_ready && (mdu_a3 != 5'd0);
        push_vld   = !(pipe_act && (mdu_a3 == pipe_a3));
    end

    // A younger pipeline write to the same register makes queued results stale.
    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_act && (a3_q[i] == pipe_a3)) vld_d[i] = 1'b0;
        end
        if (pop)  vld_d[rd_ptr_q] = 1'b0;
        if (push) vld_d[wr_ptr_q] = push_vld;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            a3_q[wr_ptr_q] <= mdu_a3;
            wd_q[wr_ptr_q] <= mdu_wd;
            pc_q[wr_ptr_q] <= mdu_pc;
        end
    end

    always_comb begin
        WE = 1'b0;
        A3 = 5'd0;
        WD = 32'd0;
        pc = 32'd0;
        if (!reset) begin
            if (pipe_act) begin
                WE = 1'b1;
                A3 = pipe_a3;
                WD = pipe_wd;
                pc = pipe_pc;
            end else if (pop && head_vld) begin
                WE = 1'b1;
                A3 = a3_q[rd_ptr_q];
                WD = wd_q[rd_ptr_q];
                pc = pc_q[rd_ptr_q];
            end
        end
    end

    always_comb begin
        q_busy1 = 1'b0;
        q_busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (a3_q[i] == q_a1)) q_busy1 = 1'b1;
            if (vld_q[i] && (a3_q[i] == q_a2)) q_busy2 = 1'b1;
        end
        if (reset || (q_a1 == 5'd0)) q_busy1 = 1'b0;
        if (reset || (q_a2 == 5'd0)) q_busy2 = 1'b0;
    end

endmodule

// File: tb/tb_grf_wb_queue.sv
// Directed bench for grf_wb_queue: hand-computed port values checked cycle by cycle.
module tb_grf_wb_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_a3;
    logic [31:0] mdu_wd;
    logic [31:0] mdu_pc;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        q_busy1;
    logic        q_busy2;
    logic        WE;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] pc;

    int n_cmp = 0;
    int n_err = 0;

    grf_wb_queue #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_a3(mdu_a3),
        .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
        .q_a1(q_a1), .q_a2(q_a2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .WE(WE), .A3(A3), .WD(WD), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pipe_we = 0; pipe_a3 = 0; pipe_wd = 0; pipe_pc = 0;
        mdu_valid = 0; mdu_a3 = 0; mdu_wd = 0; mdu_pc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mdu(input logic [4:0] a, input logic [31:0] d);
        mdu_valid = 1; mdu_a3 = a; mdu_wd = d; mdu_pc = 32'h1000 + 32'(a);
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        pipe_we = 1; pipe_a3 = a; pipe_wd = d; pipe_pc = 32'h2000 + 32'(a);
    endtask

    initial begin
        idle();
        q_a1 = 0; q_a2 = 0;
        reset = 1;
        #2;
        chk("rst_we", 32'(WE), 0);
        chk("rst_ready", 32'(mdu_ready), 0);
        step(); step();
        reset = 0;
        #1;
        chk("post_rst_ready", 32'(mdu_ready), 1);
        chk("post_rst_we", 32'(WE), 0);

        // Single MDU result: written the cycle after acceptance
        step();
        mdu(8, 32'h12345678); q_a1 = 8;
        #1;
        chk("m8_busy_acc", 32'(q_busy1), 0);
        chk("m8_we_acc", 32'(WE), 0);
        step();
        idle();
        #1;
        chk("m8_we", 32'(WE), 1);
        chk("m8_a3", 32'(A3), 8);
        chk("m8_wd", WD, 32'h12345678);
        chk("m8_pc", pc, 32'h1008);
        chk("m8_busy", 32'(q_busy1), 1);
        step();
        #1;
        chk("m8_busy_after", 32'(q_busy1), 0);
        chk("m8_we_after", 32'(WE), 0);

        // Fill while the pipeline owns the port every cycle
        for (int i = 0; i < 4; i++) begin
            pipe(5'(1 + i), 32'h100 + 32'(i));
            mdu(5'(9 + i), 32'h900 + 32'(i));
            #1;
            chk("fill_ready", 32'(mdu_ready), 1);
            chk("fill_a3", 32'(A3), 32'(1 + i));
            chk("fill_wd", WD, 32'h100 + 32'(i));
            step();
        end
        idle();
        pipe(5, 32'h55);
        #1;
        chk("full_ready", 32'(mdu_ready), 0);
        chk("full_pipe_a3", 32'(A3), 5);
        step();
        idle();
        q_a1 = 12; q_a2 = 9;
        #1;
        chk("full_busy1", 32'(q_busy1), 1);
        chk("full_busy2", 32'(q_busy2), 1);
        chk("drain_ready0", 32'(mdu_ready), 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_we", 32'(WE), 1);
            chk("drain_a3", 32'(A3), 32'(9 + i));
            chk("drain_wd", WD, 32'h900 + 32'(i));
            step();
            #1;
            chk("drain_ready", 32'(mdu_ready), 1);
        end
        chk("drain_empty_we", 32'(WE), 0);
        chk("drain_busy1", 32'(q_busy1), 0);

        // Kill a queued entry with a younger pipeline write
        mdu(5, 32'hA); q_a1 = 5; q_a2 = 0;
        step();
        idle();
        pipe(5, 32'hB);
        #1;
        chk("kill_we", 32'(WE), 1);
        chk("kill_wd", WD, 32'hB);
        chk("kill_busy_pre", 32'(q_busy1), 1);
        step();
        idle();
        #1;
        chk("kill_busy_post", 32'(q_busy1), 0);
        chk("kill_pop_we", 32'(WE), 0);
        step();
        #1;
        chk("kill_ready", 32'(mdu_ready), 1);

        // $0 accepted but not stored; pipe_a3==0 leaves the port to the FIFO
        mdu(0, 32'hDEAD);
        #1;
        chk("z_ready", 32'(mdu_ready), 1);
        step();
        idle();
        #1;
        chk("z_we", 32'(WE), 0);
        mdu(7, 32'h77);
        step();
        idle();
        pipe(0, 32'hBAD);
        #1;
        chk("p0_we", 32'(WE), 1);
        chk("p0_a3", 32'(A3), 7);
        chk("p0_wd", WD, 32'h77);
        step();
        idle();

        // Same-cycle kill: stored invalid, popped silently
        mdu(6, 32'h60); pipe(6, 32'h61); q_a1 = 6;
        #1;
        chk("sk_we", 32'(WE), 1);
        chk("sk_wd", WD, 32'h61);
        step();
        idle();
        mdu(3, 32'h33);
        #1;
        chk("sk_pop_we", 32'(WE), 0);
        chk("sk_busy", 32'(q_busy1), 0);
        step();
        idle();
        #1;
        chk("sk_next_we", 32'(WE), 1);
        chk("sk_next_a3", 32'(A3), 3);
        chk("sk_next_wd", WD, 32'h33);
        step();

        // Reset mid-drain with three entries queued
        for (int i = 0; i < 3; i++) begin
            pipe(1, 32'h1);
            mdu(5'(13 + i), 32'hD0 + 32'(i));
            step();
        end
        idle();
        q_a1 = 14;
        #1;
        chk("rd_a3", 32'(A3), 13);
        chk("rd_busy", 32'(q_busy1), 1);
        reset = 1;
        #1;
        chk("rd_we_rst", 32'(WE), 0);
        chk("rd_ready_rst", 32'(mdu_ready), 0);
        chk("rd_busy_rst", 32'(q_busy1), 0);
        step();
        reset = 0;
        #1;
        chk("rd_ready_after", 32'(mdu_ready), 1);
        chk("rd_we_after", 32'(WE), 0);
        for (int a = 0; a < 32; a++) begin
            q_a1 = 5'(a);
            #1;
            chk("rd_busy_scan", 32'(q_busy1), 0);
        end
        step();
        #1;
        chk("rd_we_idle", 32'(WE), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
